// File: rtl/nes_pkg.sv
// Shared definitions for the NES controller pad responder.
package nes_pkg;

    localparam int NES_BITS = 8;

    // Button positions inside the buttons vector / serial frame order.
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } nes_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stages;

    // Shift the raw level through the synchronizer chain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[STAGES-2:0], d};
        end
    end

    assign q = stages[STAGES-1];

endmodule

// File: rtl/nes_pad_responder.sv
// Emulates an NES controller: latches the live buttons on the console latch
// and shifts them out active-low, one bit per console shift-clock edge.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no frame since reset, nes_data parked at FILL_BIT
// LOAD  | latch high: reload shift register from buttons every cycle
// SHIFT | latch released: each pulse edge presents the next bit
// DONE  | all 8 bits consumed, nes_data parked at FILL_BIT
module nes_pad_responder
    import nes_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic FILL_BIT    = 1'b1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                nes_latch,
    input  logic                nes_pulse,
    input  logic [NES_BITS-1:0] buttons,
    output logic                nes_data,
    output logic                frame_done,
    output logic                busy
);

    logic                latch_sync;
    logic                pulse_sync;
    logic                latch_q;
    logic                pulse_q;
    logic                latch_rise;
    logic                pulse_rise;
    nes_state_e          state;
    logic [NES_BITS-1:0] shreg;
    logic [2:0]          bit_idx;
    logic [2:0]          next_idx;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_latch (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (nes_latch),
        .q       (latch_sync)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_pulse (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (nes_pulse),
        .q       (pulse_sync)
    );

    // Remember the previous synchronized levels for edge detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            latch_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            latch_q <= latch_sync;
            pulse_q <= pulse_sync;
        end
    end

    assign latch_rise = latch_sync & ~latch_q;
    assign pulse_rise = pulse_sync & ~pulse_q;
    assign next_idx   = bit_idx + 3'd1;

    // Frame sequencer; latch handling is checked first so it wins over pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            shreg      <= '1;
            bit_idx    <= 3'd0;
            nes_data   <= FILL_BIT;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    nes_data <= FILL_BIT;
                    if (latch_rise) begin
                        state    <= LOAD;
                        busy     <= 1'b1;
                        shreg    <= ~buttons;
                        bit_idx  <= 3'd0;
                        nes_data <= ~buttons[BTN_A];
                    end
                end
                LOAD: begin
                    // LOAD is only entered with latch high, so a low level here is the fall.
                    if (latch_sync) begin
                        shreg    <= ~buttons;
                        bit_idx  <= 3'd0;
                        nes_data <= ~buttons[BTN_A];
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (latch_rise) begin
                        state    <= LOAD;
                        shreg    <= ~buttons;
                        bit_idx  <= 3'd0;
                        nes_data <= ~buttons[BTN_A];
                    end else if (pulse_rise) begin
                        if (bit_idx == 3'd7) begin
                            state      <= DONE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            nes_data   <= FILL_BIT;
                        end else begin
                            bit_idx  <= next_idx;
                            nes_data <= shreg[next_idx];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nes_pad_responder.sv
// Directed bench for nes_pad_responder: table of full frames plus
// hand-written sequences for abort, reset and over-clocking cases.
module tb_nes_pad_responder;

    logic       clock;
    logic       reset_n;
    logic       nes_latch;
    logic       nes_pulse;
    logic [7:0] buttons;
    logic       nes_data;
    logic       frame_done;
    logic       busy;

    int n_total = 0;
    int n_pass  = 0;
    int fd_cnt  = 0;

    typedef struct {
        logic [7:0] btn;
        logic [7:0] exp_bits;   // exp_bits[i] = nes_data level for bit i
        logic       change_mid;
    } vec_t;

    vec_t vecs[5];

    nes_pad_responder #(.SYNC_STAGES(2), .FILL_BIT(1'b1)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .nes_latch  (nes_latch),
        .nes_pulse  (nes_pulse),
        .buttons    (buttons),
        .nes_data   (nes_data),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count cycles in which frame_done is high.
    always @(negedge clock) begin
        if (frame_done) fd_cnt <= fd_cnt + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic do_latch();
        nes_latch = 1'b1;
        cyc(6);
        nes_latch = 1'b0;
        cyc(6);
    endtask

    task automatic do_pulse();
        nes_pulse = 1'b1;
        cyc(5);
        nes_pulse = 1'b0;
        cyc(5);
    endtask

    initial begin
        int fd0;
        vecs[0] = '{btn: 8'h01, exp_bits: 8'hFE, change_mid: 1'b0};
        vecs[1] = '{btn: 8'hA5, exp_bits: 8'h5A, change_mid: 1'b1};
        vecs[2] = '{btn: 8'hFF, exp_bits: 8'h00, change_mid: 1'b0};
        vecs[3] = '{btn: 8'h80, exp_bits: 8'h7F, change_mid: 1'b0};
        vecs[4] = '{btn: 8'h3C, exp_bits: 8'hC3, change_mid: 1'b1};

        reset_n   = 1'b0;
        nes_latch = 1'b0;
        nes_pulse = 1'b0;
        buttons   = 8'h00;
        cyc(3);
        chk("reset_nes_data", 32'(nes_data), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_frame_done", 32'(frame_done), 32'd0);
        reset_n = 1'b1;
        cyc(3);
        do_pulse();
        chk("idle_pulse_nes_data", 32'(nes_data), 32'd1);
        chk("idle_pulse_busy", 32'(busy), 32'd0);

        // Full frames from the vector table.
        for (int v = 0; v < 5; v++) begin
            fd0 = fd_cnt;
            buttons = vecs[v].btn;
            nes_latch = 1'b1;
            cyc(6);
            chk($sformatf("v%0d_load_busy", v), 32'(busy), 32'd1);
            nes_latch = 1'b0;
            cyc(6);
            chk($sformatf("v%0d_bit0", v), 32'(nes_data), 32'(vecs[v].exp_bits[0]));
            for (int b = 1; b < 8; b++) begin
                if (vecs[v].change_mid && b == 3) buttons = 8'h00;
                do_pulse();
                chk($sformatf("v%0d_bit%0d", v, b), 32'(nes_data), 32'(vecs[v].exp_bits[b]));
            end
            chk($sformatf("v%0d_no_early_done", v), 32'(fd_cnt - fd0), 32'd0);
            do_pulse();
            chk($sformatf("v%0d_fill", v), 32'(nes_data), 32'd1);
            chk($sformatf("v%0d_idle_busy", v), 32'(busy), 32'd0);
            chk($sformatf("v%0d_frame_done", v), 32'(fd_cnt - fd0), 32'd1);
        end

        // Latch held 10+ cycles, buttons toggle, pulses during latch ignored.
        fd0 = fd_cnt;
        buttons = 8'h00;
        nes_latch = 1'b1;
        cyc(5);
        chk("hold_bit0_released", 32'(nes_data), 32'd1);
        nes_pulse = 1'b1;
        cyc(3);
        nes_pulse = 1'b0;
        buttons = 8'h01;
        cyc(5);
        chk("hold_bit0_pressed", 32'(nes_data), 32'd0);
        nes_latch = 1'b0;
        cyc(6);
        chk("hold_after_fall", 32'(nes_data), 32'd0);
        for (int b = 1; b < 8; b++) do_pulse();
        chk("hold_7pulses_busy", 32'(busy), 32'd1);
        chk("hold_7pulses_nodone", 32'(fd_cnt - fd0), 32'd0);
        do_pulse();
        chk("hold_8pulses_done", 32'(fd_cnt - fd0), 32'd1);

        // Abort mid-frame with a fresh latch.
        fd0 = fd_cnt;
        buttons = 8'hA5;
        do_latch();
        do_pulse(); do_pulse(); do_pulse();
        chk("abort_bit3", 32'(nes_data), 32'd1);
        buttons = 8'h01;
        do_latch();
        chk("abort_restart_bit0", 32'(nes_data), 32'd0);
        do_pulse();
        chk("abort_restart_bit1", 32'(nes_data), 32'd1);
        for (int b = 2; b < 9; b++) do_pulse();
        chk("abort_one_done", 32'(fd_cnt - fd0), 32'd1);

        // Latch and pulse rising together: latch wins.
        buttons = 8'h00;
        do_latch();
        do_pulse();
        buttons = 8'h01;
        nes_latch = 1'b1;
        nes_pulse = 1'b1;
        cyc(6);
        chk("tie_loaded", 32'(nes_data), 32'd0);
        nes_latch = 1'b0;
        nes_pulse = 1'b0;
        cyc(6);
        chk("tie_bit0", 32'(nes_data), 32'd0);
        chk("tie_busy", 32'(busy), 32'd1);

        // Asynchronous reset mid-frame.
        buttons = 8'hFF;
        do_latch();
        do_pulse(); do_pulse(); do_pulse(); do_pulse();
        chk("pre_reset_bit4", 32'(nes_data), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_nes_data", 32'(nes_data), 32'd1);
        chk("async_reset_busy", 32'(busy), 32'd0);
        cyc(2);
        reset_n = 1'b1;
        cyc(3);
        do_pulse();
        chk("post_reset_pulse_nes_data", 32'(nes_data), 32'd1);
        chk("post_reset_pulse_busy", 32'(busy), 32'd0);

        // 12 pulses: one frame_done, pulses 9-12 hold fill level.
        fd0 = fd_cnt;
        buttons = 8'hFF;
        do_latch();
        for (int p = 1; p <= 12; p++) begin
            do_pulse();
            if (p >= 8) chk($sformatf("over_p%0d_fill", p), 32'(nes_data), 32'd1);
            else chk($sformatf("over_p%0d_bit", p), 32'(nes_data), 32'd0);
        end
        chk("over_one_done", 32'(fd_cnt - fd0), 32'd1);

        // Latch already high when reset releases counts as a rising edge.
        reset_n = 1'b0;
        buttons = 8'h01;
        nes_latch = 1'b1;
        cyc(2);
        reset_n = 1'b1;
        cyc(6);
        chk("release_latch_busy", 32'(busy), 32'd1);
        chk("release_latch_bit0", 32'(nes_data), 32'd0);
        nes_latch = 1'b0;
        cyc(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/nes_pad_responder.md
NES_PAD_RESPONDER -- requirements
Module: nes_pad_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flops in each input synchronizer (minimum 2).
REQ-002 SHALL have parameter FILL_BIT, default 1'b1, level driven on nes_data after all 8 bits are shifted out.
REQ-003 SHALL have port clock  input  1  system clock; the block's only clock.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port nes_latch  input  1  console latch, asynchronous to clock, active-high.
REQ-006 SHALL have port nes_pulse  input  1  console shift clock, asynchronous to clock, rising edge advances one bit.
REQ-007 SHALL have port buttons  input  8  live button state, 1 = pressed; [0]=A, [1]=B, [2]=Select, [3]=Start, [4]=Up, [5]=Down, [6]=Left, [7]=Right.
REQ-008 SHALL have port nes_data  output  1  serial data to console, active-low (0 = pressed), registered.
REQ-009 SHALL have port frame_done  output  1  one-cycle pulse when the 8th bit has been consumed.
REQ-010 SHALL have port busy  output  1  high while in LOAD or SHIFT.

Function
REQ-011 SHALL pass nes_latch and nes_pulse through separate SYNC_STAGES-flop synchronizers, then one edge-detect register each.
REQ-012 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE.
REQ-013 IDLE: nes_data = FILL_BIT; synchronized latch rising edge -> LOAD.
REQ-014 LOAD: every cycle while synchronized latch is high, SHALL copy ~buttons into the 8-bit shift register, set bit index to 0, and drive nes_data = ~buttons[0].
REQ-015 LOAD: synchronized latch falling edge -> SHIFT, holding the last loaded value; nes_pulse edges while latch is high SHALL be ignored.
REQ-016 SHIFT: each synchronized nes_pulse rising edge SHALL increment the bit index; nes_data = shift register bit at the new index for indices 1..7.
REQ-017 SHIFT: the rising edge at index 7 SHALL move to DONE, assert frame_done for exactly one cycle, and drive nes_data = FILL_BIT.
REQ-018 DONE: further nes_pulse edges SHALL keep nes_data = FILL_BIT with no further frame_done; latch rising edge -> LOAD.
REQ-019 SHIFT: latch rising edge mid-frame SHALL abort the frame (no frame_done) and go to LOAD.
REQ-020 Latch and pulse rising edges detected in the same cycle: latch SHALL win.
REQ-021 nes_data SHALL change exactly SYNC_STAGES+1 clock cycles after the first clock edge sampling the new input level.
REQ-022 Bit index SHALL be 3 bits and never wrap past 7; FSM in DONE bounds it.
REQ-023 buttons SHALL be sampled only in LOAD; changes during SHIFT/DONE SHALL not affect the current frame.

Reset
REQ-024 reset_n low SHALL asynchronously force state IDLE, shift register 8'hFF, bit index 0, nes_data = FILL_BIT, frame_done 0, busy 0, all synchronizer and edge flops 0.
REQ-025 Reset release mid-frame SHALL wait for a fresh latch rising edge; a latch already high at release SHALL count as a rising edge.

Structure
REQ-026 Shared package nes_pkg SHALL hold the FSM state enum, button index constants (BTN_A..BTN_RIGHT) and NES_BITS = 8.
REQ-027 Synchronizer SHALL be a sub-module sync_ff (parameter STAGES), instantiated twice.

Verification
REQ-028 buttons=8'h01, latch pulse then 8 nes_pulse edges -> nes_data sequence 0,1,1,1,1,1,1,1 then 1; one frame_done.
REQ-029 buttons=8'hA5 -> bits observed 0,1,0,1,1,0,1,0; changing buttons to 8'h00 mid-shift leaves sequence unchanged.
REQ-030 Latch held high 10 cycles while buttons toggles 8'h00->8'h01 -> nes_data follows ~buttons[0] (1 then 0); pulses during latch ignored.
REQ-031 Latch rising edge after 3 pulses -> frame restarts at bit 0, no frame_done for aborted frame.
REQ-032 reset_n asserted after 4 pulses -> nes_data=1, busy=0 immediately (asynchronous); next pulse without latch leaves nes_data=1.
REQ-033 12 pulses after latch -> exactly one frame_done on 8th; pulses 9-12 keep nes_data=1.
